// File: rtl/jk_mode_counter.sv
// Multi-bit JK register/counter: every mode is reduced to per-bit J/K drives
// that feed one shared array of JK cells.
module jk_mode_counter #(
  parameter int WIDTH    = 4,
  parameter int MOD      = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_COUNT = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_RAW   = 2'b11
  } mode_t;

  // Top of the count range; comparing against MAX_Q keeps all arithmetic in WIDTH bits.
  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO_Q = '0;
  localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

  mode_t            mode_sel;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] j_drv;
  logic [WIDTH-1:0] k_drv;
  logic             wrap_next;

  assign mode_sel = mode_t'(mode);

  always_comb begin
    target    = q;
    wrap_next = 1'b0;
    case (mode_sel)
      MODE_LOAD: target = (d > MAX_Q) ? MAX_Q : d;
      MODE_COUNT: begin
        if (q > MAX_Q) begin
          target = ZERO_Q;
        end else if (up_dn) begin
          if (q == MAX_Q) begin
            target    = SATURATE ? q : ZERO_Q;
            wrap_next = !SATURATE;
          end else begin
            target = q + ONE_Q;
          end
        end else begin
          if (q == ZERO_Q) begin
            target    = SATURATE ? q : MAX_Q;
            wrap_next = !SATURATE;
          end else begin
            target = q - ONE_Q;
          end
        end
      end
      default: target = q;
    endcase
  end

  // COUNT/LOAD reach their target by toggling exactly the bits that differ.
  always_comb begin
    j_drv = '0;
    k_drv = '0;
    case (mode_sel)
      MODE_RAW: begin
        j_drv = j;
        k_drv = k;
      end
      MODE_COUNT, MODE_LOAD: begin
        j_drv = q ^ target;
        k_drv = q ^ target;
      end
      default: begin
        j_drv = '0;
        k_drv = '0;
      end
    endcase
  end

  assign tc = (mode_sel == MODE_COUNT) &&
              ((up_dn && (q == MAX_Q)) || (!up_dn && (q == ZERO_Q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j_drv[i], k_drv[i]})
          2'b01:   q[i] <= 1'b0;
          2'b10:   q[i] <= 1'b1;
          2'b11:   q[i] <= ~q[i];
          default: q[i] <= q[i];
        endcase
      end
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_jk_mode_counter.sv
// Directed checks of jk_mode_counter (MOD=10 wrap/saturate, MOD=16) plus a
// randomised MOD=16 run against a small reference model.
module tb_jk_mode_counter;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       up_dn;
  logic [3:0] j, k, d;

  logic [3:0] q10, q10s, q16;
  logic       tc10, tc10s, tc16;
  logic       wrap10, wrap10s, wrap16;

  int n_tests;
  int n_fail;

  jk_mode_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .up_dn(up_dn),
    .j(j), .k(k), .d(d), .q(q10), .tc(tc10), .wrap(wrap10)
  );

  jk_mode_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mode(mode), .up_dn(up_dn),
    .j(j), .k(k), .d(d), .q(q10s), .tc(tc10s), .wrap(wrap10s)
  );

  jk_mode_counter #(.WIDTH(4), .MOD(16), .SATURATE(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .up_dn(up_dn),
    .j(j), .k(k), .d(d), .q(q16), .tc(tc16), .wrap(wrap16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic u, input logic [3:0] jj,
                       input logic [3:0] kk, input logic [3:0] dd);
    mode  = m;
    up_dn = u;
    j     = jj;
    k     = kk;
    d     = dd;
  endtask

  logic [3:0] mq;
  logic       mw;
  logic       mtc;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(2'b00, 1'b1, 4'h0, 4'h0, 4'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("reset_q", q10, 0);
    check("reset_wrap", wrap10, 0);
    check("reset_tc_hold", tc10, 0);

    // count up 12 edges, MOD=10 wraps
    drive(2'b01, 1'b1, 4'h0, 4'h0, 4'h0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("up_q_%0d", i), q10, i % 10);
      check($sformatf("up_wrap_%0d", i), wrap10, (i % 10) == 0);
      check($sformatf("up_tc_%0d", i), tc10, (i % 10) == 9);
    end
    check("up_sat_q", q10s, 9);
    check("up_sat_wrap", wrap10s, 0);
    check("up16_q", q16, 12);

    // asynchronous reset between edges from q=7
    drive(2'b10, 1'b1, 4'h0, 4'h0, 4'h7);
    tick();
    check("load7_q", q10, 7);
    drive(2'b00, 1'b1, 4'h0, 4'h0, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_q", q10, 0);
    check("async_rst_wrap", wrap10, 0);
    check("async_rst_q16", q16, 0);
    rst_n = 1'b1;

    // count down from 0
    tick();
    drive(2'b01, 1'b0, 4'h0, 4'h0, 4'h0);
    #1;
    check("down_tc_at0", tc10, 1);
    tick();
    check("down_q", q10, 9);
    check("down_wrap", wrap10, 1);
    check("down_sat_q", q10s, 0);
    check("down_sat_wrap", wrap10s, 0);
    check("down16_q", q16, 15);
    check("down16_wrap", wrap16, 1);

    // load clamp, load, hold
    drive(2'b10, 1'b1, 4'h0, 4'h0, 4'hC);
    tick();
    check("load_clamp_q", q10, 9);
    check("load_clamp_wrap", wrap10, 0);
    check("load16_noclamp", q16, 12);
    drive(2'b10, 1'b1, 4'h0, 4'h0, 4'h3);
    tick();
    check("load3_q", q10, 3);
    drive(2'b00, 1'b1, 4'hF, 4'hF, 4'h9);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_q_%0d", i), q10, 3);
      check($sformatf("hold_tc_%0d", i), tc10, 0);
    end

    // raw J/K drive then recovery count
    drive(2'b10, 1'b1, 4'h0, 4'h0, 4'b0101);
    tick();
    check("raw_pre_q", q10, 5);
    drive(2'b11, 1'b1, 4'b1100, 4'b1010, 4'h0);
    tick();
    check("raw_q", q10, 13);
    check("raw_wrap", wrap10, 0);
    drive(2'b01, 1'b1, 4'h0, 4'h0, 4'h0);
    #1;
    check("oor_tc", tc10, 0);
    tick();
    check("recover_q", q10, 0);
    check("recover_wrap", wrap10, 0);

    // randomised MOD=16 against reference model
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    mq = 4'h0;
    mw = 1'b0;
    for (int n = 0; n < 255; n++) begin
      drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
      if ($urandom_range(0, 15) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        mq = 4'h0;
        mw = 1'b0;
        check("rnd_rst_q", q16, mq);
        check("rnd_rst_wrap", wrap16, mw);
        rst_n = 1'b1;
      end
      #1;
      mtc = (mode == 2'b01) && ((up_dn && mq == 4'd15) || (!up_dn && mq == 4'd0));
      check("rnd_tc", tc16, mtc);
      mw = 1'b0;
      case (mode)
        2'b01: begin
          if (up_dn) begin
            if (mq == 4'd15) begin mq = 4'd0; mw = 1'b1; end
            else mq = mq + 4'd1;
          end else begin
            if (mq == 4'd0) begin mq = 4'd15; mw = 1'b1; end
            else mq = mq - 4'd1;
          end
        end
        2'b10:   mq = d;
        2'b11:   mq = (j & ~mq) | (~k & mq);
        default: mq = mq;
      endcase
      tick();
      check("rnd_q", q16, mq);
      check("rnd_wrap", wrap16, mw);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
